sudoku_cell_p: RTL and testbench

SUDOKU_CELL_P -- requirements
Module: sudoku_cell_p

---
 rtl/sudoku_cell_p.sv | 154 +++++++++++++++
 tb/tb_sudoku_cell_p.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_cell_p.sv
// One Sudoku cell: solved value, pencil marks, live candidate set and a small
// snapshot stack for backtracking. One operation is applied per clock.
module sudoku_cell_p #(
    parameter int N     = 9,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  wr_data,
    output logic [N-1:0]  rd_data,
    input  logic [1:0]    address,
    input  logic          we,
    input  logic          oe,
    input  logic          latch_valid,
    input  logic          latch_singleton,
    input  logic          push,
    input  logic          pop,
    output logic          is_singleton,
    output logic          solved,
    output logic          conflict,
    output logic [CW-1:0] cand_count,
    output logic          stack_full,
    output logic          stack_empty,
    output logic          overflow,
    output logic          underflow
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [N-1:0]  value_reg, value_next;
    logic [N-1:0]  pencil_reg, pencil_next;
    logic [N-1:0]  valid_reg, valid_next;
    logic [DW-1:0] depth_reg, depth_next;
    logic          overflow_reg, overflow_next;
    logic          underflow_reg, underflow_next;
    logic          push_fire;

    logic [3*N-1:0] stack_mem [DEPTH];
    logic [3*N-1:0] top_entry;
    logic [AW-1:0]  wr_addr;
    logic [AW-1:0]  rd_addr;

    // Candidate count as a running sum over the valid bits.
    logic [CW-1:0] psum [N+1];
    assign psum[0] = '0;
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_popcount
            assign psum[gi+1] = psum[gi] + CW'(valid_reg[gi]);
        end
    endgenerate

    assign cand_count   = psum[N];
    assign is_singleton = (cand_count == CW'(1));
    assign solved       = (value_reg != '0);
    assign conflict     = (value_reg == '0) && (valid_reg == '0);
    assign stack_full   = (depth_reg == DW'(DEPTH));
    assign stack_empty  = (depth_reg == '0);
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    assign wr_addr   = AW'(depth_reg);
    assign rd_addr   = AW'(depth_reg - DW'(1));
    assign top_entry = stack_mem[rd_addr];

    always_comb begin
        rd_data = '0;
        if (oe) begin
            case (address)
                2'd0:    rd_data = value_reg;
                2'd1:    rd_data = pencil_reg;
                2'd2:    rd_data = valid_reg;
                default: rd_data = N'(cand_count);
            endcase
        end
    end

    always_comb begin
        value_next     = value_reg;
        pencil_next    = pencil_reg;
        valid_next     = valid_reg;
        depth_next     = depth_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        push_fire      = 1'b0;

        if (we) begin
            // A write owns the cycle even for the read-only addresses, so any
            // concurrent push/pop is swallowed without touching the flags.
            case (address)
                2'd0: begin
                    value_next = wr_data;
                    valid_next = (wr_data == '0) ? ~pencil_reg : '0;
                end
                2'd1: begin
                    pencil_next = wr_data;
                    valid_next  = (value_reg == '0) ? ~wr_data : '0;
                end
                default: ;
            endcase
        end else if (pop) begin
            if (stack_empty) begin
                underflow_next = 1'b1;
            end else begin
                {value_next, pencil_next, valid_next} = top_entry;
                depth_next = depth_reg - DW'(1);
            end
        end else if (push) begin
            if (stack_full) begin
                overflow_next = 1'b1;
            end else begin
                push_fire  = 1'b1;
                depth_next = depth_reg + DW'(1);
            end
        end else if (latch_valid) begin
            if (value_reg == '0) begin
                valid_next = valid_reg & wr_data;
            end
        end else if (latch_singleton) begin
            if ((value_reg == '0) && is_singleton) begin
                value_next = valid_reg;
                valid_next = '0;
            end else begin
                valid_next = (value_reg == '0) ? ~pencil_reg : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_reg     <= '0;
            pencil_reg    <= '0;
            valid_reg     <= '1;
            depth_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            value_reg     <= value_next;
            pencil_reg    <= pencil_next;
            valid_reg     <= valid_next;
            depth_reg     <= depth_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire && !reset) begin
            stack_mem[wr_addr] <= {value_reg, pencil_reg, valid_reg};
        end
    end

endmodule

// File: tb/tb_sudoku_cell_p.sv
// Table-driven bench for sudoku_cell_p at N=9, N=4 and N=16 (all DEPTH=2);
// expected records are queued when driven and checked after the clock edge.
module tb_sudoku_cell_p;

    typedef struct {
        int          sel;
        logic        rst;
        logic        we;
        logic [1:0]  addr;
        logic [15:0] wr;
        logic        lv;
        logic        ls;
        logic        psh;
        logic        pp;
        logic        oe;
        logic [15:0] rd;
        logic [4:0]  cnt;
        logic [6:0]  st;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] wr_data = '0;
    logic [1:0]  address = '0;
    logic        we = 1'b0, oe = 1'b0, lv = 1'b0, ls = 1'b0, push = 1'b0, pop = 1'b0;

    logic [8:0]  rd9;  logic [3:0] cnt9;
    logic [3:0]  rd4;  logic [2:0] cnt4;
    logic [15:0] rd16; logic [4:0] cnt16;
    logic [6:0]  st9, st4, st16;

    always #5 clk = ~clk;

    sudoku_cell_p #(.N(9), .DEPTH(2)) u_n9 (
        .clk(clk), .reset(reset), .wr_data(wr_data[8:0]), .rd_data(rd9),
        .address(address), .we(we), .oe(oe), .latch_valid(lv), .latch_singleton(ls),
        .push(push), .pop(pop), .is_singleton(st9[6]), .solved(st9[5]), .conflict(st9[4]),
        .cand_count(cnt9), .stack_full(st9[3]), .stack_empty(st9[2]),
        .overflow(st9[1]), .underflow(st9[0]));

    sudoku_cell_p #(.N(4), .DEPTH(2)) u_n4 (
        .clk(clk), .reset(reset), .wr_data(wr_data[3:0]), .rd_data(rd4),
        .address(address), .we(we), .oe(oe), .latch_valid(lv), .latch_singleton(ls),
        .push(push), .pop(pop), .is_singleton(st4[6]), .solved(st4[5]), .conflict(st4[4]),
        .cand_count(cnt4), .stack_full(st4[3]), .stack_empty(st4[2]),
        .overflow(st4[1]), .underflow(st4[0]));

    sudoku_cell_p #(.N(16), .DEPTH(2)) u_n16 (
        .clk(clk), .reset(reset), .wr_data(wr_data), .rd_data(rd16),
        .address(address), .we(we), .oe(oe), .latch_valid(lv), .latch_singleton(ls),
        .push(push), .pop(pop), .is_singleton(st16[6]), .solved(st16[5]), .conflict(st16[4]),
        .cand_count(cnt16), .stack_full(st16[3]), .stack_empty(st16[2]),
        .overflow(st16[1]), .underflow(st16[0]));

    vec_t exp_q[$];
    vec_t tbl[$];
    int   n_applied = 0;
    int   n_miscompares = 0;

    function automatic vec_t mk(int sel, logic rst, logic w, logic [1:0] a, logic [15:0] d,
                                logic l_v, logic l_s, logic ps, logic pp, logic o,
                                logic [15:0] rd, logic [4:0] cnt, logic [6:0] st);
        vec_t v;
        v.sel = sel; v.rst = rst; v.we = w; v.addr = a; v.wr = d;
        v.lv = l_v; v.ls = l_s; v.psh = ps; v.pp = pp; v.oe = o;
        v.rd = rd; v.cnt = cnt; v.st = st;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        @(negedge clk);
        reset = v.rst; we = v.we; address = v.addr; wr_data = v.wr;
        lv = v.lv; ls = v.ls; push = v.psh; pop = v.pp; oe = v.oe;
        exp_q.push_back(v);
    endtask

    logic [15:0] a_rd;
    logic [4:0]  a_cnt;
    logic [6:0]  a_st;
    vec_t        e;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            case (e.sel)
                0:       begin a_rd = {7'd0, rd9};  a_cnt = {1'b0, cnt9};  a_st = st9;  end
                1:       begin a_rd = {12'd0, rd4}; a_cnt = {2'b0, cnt4};  a_st = st4;  end
                default: begin a_rd = rd16;         a_cnt = cnt16;         a_st = st16; end
            endcase
            if (a_rd !== e.rd) begin
                n_miscompares++;
                $display("FAIL vec%0d rd_data: got %h want %h", n_applied, a_rd, e.rd);
            end
            if (a_cnt !== e.cnt) begin
                n_miscompares++;
                $display("FAIL vec%0d cand_count: got %0d want %0d", n_applied, a_cnt, e.cnt);
            end
            if (a_st !== e.st) begin
                n_miscompares++;
                $display("FAIL vec%0d status{sing,solv,conf,full,empty,ovf,unf}: got %b want %b",
                         n_applied, a_st, e.st);
            end
            $display("vec%0d inst=%0d rd=%h cnt=%0d st=%b", n_applied, e.sel, a_rd, a_cnt, a_st);
            n_applied++;
        end
    end

    initial begin
        // N=9: elimination down to one candidate, then promote it
        tbl.push_back(mk(0,1,0,3,16'h000,0,0,0,0,1,16'd9,  5'd9,7'b0000100));
        tbl.push_back(mk(0,0,0,3,16'h000,0,0,0,0,0,16'h000,5'd9,7'b0000100));
        tbl.push_back(mk(0,0,0,2,16'h1FE,1,0,0,0,1,16'h1FE,5'd8,7'b0000100));
        tbl.push_back(mk(0,0,0,2,16'h1EF,1,0,0,0,1,16'h1EE,5'd7,7'b0000100));
        tbl.push_back(mk(0,0,0,3,16'h004,1,0,0,0,1,16'h001,5'd1,7'b1000100));
        tbl.push_back(mk(0,0,0,0,16'h000,0,1,0,0,1,16'h004,5'd0,7'b0100100));
        // N=9: pencil marks, unsolvable cell, latch_singleton fallback
        tbl.push_back(mk(0,1,0,1,16'h000,0,0,0,0,1,16'h000,5'd9,7'b0000100));
        tbl.push_back(mk(0,0,1,1,16'h1FF,0,0,0,0,1,16'h1FF,5'd0,7'b0010100));
        tbl.push_back(mk(0,0,0,2,16'h000,0,1,0,0,1,16'h000,5'd0,7'b0010100));
        tbl.push_back(mk(0,0,0,0,16'h000,0,0,0,0,1,16'h000,5'd0,7'b0010100));
        tbl.push_back(mk(0,0,1,1,16'h0F0,0,0,0,0,1,16'h0F0,5'd5,7'b0000100));
        tbl.push_back(mk(0,0,0,2,16'h00F,1,0,0,0,1,16'h00F,5'd4,7'b0000100));
        tbl.push_back(mk(0,0,0,2,16'h000,0,1,0,0,1,16'h10F,5'd5,7'b0000100));
        tbl.push_back(mk(0,0,1,0,16'h030,0,0,0,0,1,16'h030,5'd0,7'b0100100));
        tbl.push_back(mk(0,0,1,0,16'h000,0,0,0,0,1,16'h000,5'd5,7'b0000100));
        tbl.push_back(mk(0,0,1,2,16'h1FF,0,0,0,0,1,16'h10F,5'd5,7'b0000100));
        tbl.push_back(mk(0,0,1,1,16'h000,0,0,0,0,1,16'h000,5'd9,7'b0000100));
        tbl.push_back(mk(0,0,1,0,16'h080,0,0,0,0,1,16'h080,5'd0,7'b0100100));
        tbl.push_back(mk(0,0,1,1,16'h001,0,0,0,0,1,16'h001,5'd0,7'b0100100));
        tbl.push_back(mk(0,0,0,2,16'h000,0,1,0,0,1,16'h000,5'd0,7'b0100100));
        // N=9: backtracking round trip
        tbl.push_back(mk(0,1,0,3,16'h000,0,0,0,0,1,16'd9,  5'd9,7'b0000100));
        tbl.push_back(mk(0,0,1,1,16'h003,0,0,0,0,1,16'h003,5'd7,7'b0000100));
        tbl.push_back(mk(0,0,0,2,16'h000,0,0,1,0,1,16'h1FC,5'd7,7'b0000000));
        tbl.push_back(mk(0,0,1,0,16'h010,0,0,0,0,1,16'h010,5'd0,7'b0100000));
        tbl.push_back(mk(0,0,0,0,16'h000,0,0,0,1,1,16'h000,5'd7,7'b0000100));
        tbl.push_back(mk(0,0,0,1,16'h000,0,0,0,0,1,16'h003,5'd7,7'b0000100));
        tbl.push_back(mk(0,0,0,2,16'h000,0,0,0,0,1,16'h1FC,5'd7,7'b0000100));
        // N=9: operation priorities
        tbl.push_back(mk(0,0,0,2,16'h000,0,0,1,0,1,16'h1FC,5'd7,7'b0000000));
        tbl.push_back(mk(0,0,1,1,16'h00F,1,0,0,1,1,16'h00F,5'd5,7'b0000000));
        tbl.push_back(mk(0,0,0,1,16'h000,0,0,1,1,1,16'h003,5'd7,7'b0000100));
        tbl.push_back(mk(0,0,0,2,16'h000,1,0,1,0,1,16'h1FC,5'd7,7'b0000000));
        tbl.push_back(mk(0,1,0,3,16'h000,0,0,1,0,1,16'd9,  5'd9,7'b0000100));
        tbl.push_back(mk(0,0,1,3,16'h1FF,0,0,0,1,1,16'd9,  5'd9,7'b0000100));
        // N=9: stack bounds at DEPTH=2
        tbl.push_back(mk(0,0,1,1,16'h100,0,0,0,0,1,16'h100,5'd8,7'b0000100));
        tbl.push_back(mk(0,0,0,3,16'h000,0,0,1,0,1,16'd8,  5'd8,7'b0000000));
        tbl.push_back(mk(0,0,1,1,16'h101,0,0,0,0,1,16'h101,5'd7,7'b0000000));
        tbl.push_back(mk(0,0,0,3,16'h000,0,0,1,0,1,16'd7,  5'd7,7'b0001000));
        tbl.push_back(mk(0,0,1,2,16'h000,0,0,1,0,1,16'h0FE,5'd7,7'b0001000));
        tbl.push_back(mk(0,0,0,3,16'h000,0,0,1,0,1,16'd7,  5'd7,7'b0001010));
        tbl.push_back(mk(0,0,0,1,16'h000,0,0,0,1,1,16'h101,5'd7,7'b0000010));
        tbl.push_back(mk(0,0,0,1,16'h000,0,0,0,1,1,16'h100,5'd8,7'b0000110));
        tbl.push_back(mk(0,0,0,1,16'h000,0,0,0,1,1,16'h100,5'd8,7'b0000111));
        tbl.push_back(mk(0,0,0,2,16'h000,0,0,0,0,1,16'h0FF,5'd8,7'b0000111));
        tbl.push_back(mk(0,1,0,3,16'h000,0,0,0,0,1,16'd9,  5'd9,7'b0000100));
        // N=4: singleton and stack bounds
        tbl.push_back(mk(1,1,0,3,16'h000,0,0,0,0,1,16'd4,  5'd4,7'b0000100));
        tbl.push_back(mk(1,0,0,2,16'h00E,1,0,0,0,1,16'h00E,5'd3,7'b0000100));
        tbl.push_back(mk(1,0,0,3,16'h005,1,0,0,0,1,16'h001,5'd1,7'b1000100));
        tbl.push_back(mk(1,0,0,0,16'h000,0,1,0,0,1,16'h004,5'd0,7'b0100100));
        tbl.push_back(mk(1,1,0,3,16'h000,0,0,0,0,1,16'd4,  5'd4,7'b0000100));
        tbl.push_back(mk(1,0,1,1,16'h008,0,0,0,0,1,16'h008,5'd3,7'b0000100));
        tbl.push_back(mk(1,0,0,3,16'h000,0,0,1,0,1,16'd3,  5'd3,7'b0000000));
        tbl.push_back(mk(1,0,1,1,16'h009,0,0,0,0,1,16'h009,5'd2,7'b0000000));
        tbl.push_back(mk(1,0,0,3,16'h000,0,0,1,0,1,16'd2,  5'd2,7'b0001000));
        tbl.push_back(mk(1,0,0,3,16'h000,0,0,1,0,1,16'd2,  5'd2,7'b0001010));
        tbl.push_back(mk(1,0,0,1,16'h000,0,0,0,1,1,16'h009,5'd2,7'b0000010));
        tbl.push_back(mk(1,0,0,1,16'h000,0,0,0,1,1,16'h008,5'd3,7'b0000110));
        tbl.push_back(mk(1,0,0,1,16'h000,0,0,0,1,1,16'h008,5'd3,7'b0000111));
        // N=16: singleton and stack bounds
        tbl.push_back(mk(2,1,0,3,16'h0000,0,0,0,0,1,16'd16,  5'd16,7'b0000100));
        tbl.push_back(mk(2,0,0,2,16'hFFFE,1,0,0,0,1,16'hFFFE,5'd15,7'b0000100));
        tbl.push_back(mk(2,0,0,3,16'h8001,1,0,0,0,1,16'h0001,5'd1, 7'b1000100));
        tbl.push_back(mk(2,0,0,0,16'h0000,0,1,0,0,1,16'h8000,5'd0, 7'b0100100));
        tbl.push_back(mk(2,1,0,3,16'h0000,0,0,0,0,1,16'd16,  5'd16,7'b0000100));
        tbl.push_back(mk(2,0,1,1,16'h00FF,0,0,0,0,1,16'h00FF,5'd8, 7'b0000100));
        tbl.push_back(mk(2,0,0,3,16'h0000,0,0,1,0,1,16'd8,   5'd8, 7'b0000000));
        tbl.push_back(mk(2,0,1,1,16'h0FFF,0,0,0,0,1,16'h0FFF,5'd4, 7'b0000000));
        tbl.push_back(mk(2,0,0,3,16'h0000,0,0,1,0,1,16'd4,   5'd4, 7'b0001000));
        tbl.push_back(mk(2,0,0,3,16'h0000,0,0,1,0,1,16'd4,   5'd4, 7'b0001010));
        tbl.push_back(mk(2,0,0,1,16'h0000,0,0,0,1,1,16'h0FFF,5'd4, 7'b0000010));
        tbl.push_back(mk(2,0,0,1,16'h0000,0,0,0,1,1,16'h00FF,5'd8, 7'b0000110));
        tbl.push_back(mk(2,0,0,1,16'h0000,0,0,0,1,1,16'h00FF,5'd8, 7'b0000111));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Reset landing on a full stack alongside we/push/pop must leave it empty.
        apply(mk(0,1,0,3,16'h000,0,0,0,0,1,16'd9,  5'd9,7'b0000100));
        apply(mk(0,0,1,1,16'h0FF,0,0,0,0,1,16'h0FF,5'd1,7'b1000100));
        apply(mk(0,0,0,3,16'h000,0,0,1,0,1,16'd1,  5'd1,7'b1000000));
        apply(mk(0,0,0,3,16'h000,0,0,1,0,1,16'd1,  5'd1,7'b1001000));
        apply(mk(0,1,1,3,16'h1FF,0,0,1,1,1,16'd9,  5'd9,7'b0000100));
        apply(mk(0,0,0,3,16'h000,0,0,0,1,1,16'd9,  5'd9,7'b0000101));

        @(negedge clk);
        we = 1'b0; push = 1'b0; pop = 1'b0; lv = 1'b0; ls = 1'b0; reset = 1'b0;
        for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_miscompares++;
            $display("FAIL drain: %0d expected records left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
